// File: rtl/mfp_ahb_loader_arbiter_if.sv
// ---------------------------------------------------------------------------
// mfp_ahb_loader_arbiter_if
// Bus bundle around the loader arbiter: the CPU AHB-Lite master port
// (cpu_*), the arbitrated port toward mfp_ahb (m_*) and the slave HREADY.
//   master : arbiter view   (cpu_* / HREADY in, m_* out)
//   slave  : environment view (cpu_* / HREADY out, m_* in)
// cpu_HSIDE / m_HSIDE carry {HMASTLOCK, HPROT[3:0], HBURST[2:0]}.
// ---------------------------------------------------------------------------
interface mfp_ahb_loader_arbiter_if #(
   parameter int unsigned ADDR_W = 32
);
   logic [ADDR_W-1:0] cpu_HADDR;
   logic [1:0]        cpu_HTRANS;
   logic [2:0]        cpu_HSIZE;
   logic              cpu_HWRITE;
   logic [31:0]       cpu_HWDATA;
   logic [7:0]        cpu_HSIDE;

   logic [ADDR_W-1:0] m_HADDR;
   logic [1:0]        m_HTRANS;
   logic [2:0]        m_HSIZE;
   logic              m_HWRITE;
   logic [31:0]       m_HWDATA;
   logic [7:0]        m_HSIDE;

   logic              HREADY;

   modport master (
      input  cpu_HADDR, cpu_HTRANS, cpu_HSIZE, cpu_HWRITE, cpu_HWDATA, cpu_HSIDE, HREADY,
      output m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA, m_HSIDE
   );

   modport slave (
      output cpu_HADDR, cpu_HTRANS, cpu_HSIZE, cpu_HWRITE, cpu_HWDATA, cpu_HSIDE, HREADY,
      input  m_HADDR, m_HTRANS, m_HSIZE, m_HWRITE, m_HWDATA, m_HSIDE
   );
endinterface

// File: rtl/mfp_ahb_loader_arbiter.sv
// ---------------------------------------------------------------------------
// mfp_ahb_loader_arbiter
// Buffered AHB-Lite loader master plus 2:1 arbiter between the CPU and the
// loader. Parser byte writes are queued and issued as single write transfers;
// ownership only moves at transfer boundaries.
// Ports:
//   HCLK, HRESET       clock, synchronous active-high reset
//   big_endian         lane order for coalesced word writes
//   ld_addr/ld_byte/ld_valid  parser byte-write stream
//   ld_active          serial load in progress (requests the bus)
//   bus                cpu_* in, m_* out, HREADY in (interface, master view)
//   grant_loader       address-phase owner is the loader
//   load_busy          queue / assembly / loader transfer still pending
//   overflow           sticky byte-drop flag
//   fifo_level         queued entries
// Build option: define MFP_LOADER_COALESCE_EN to merge consecutive bytes
// into aligned word writes (FLUSH_CYCLES sets the partial-word timeout).
// ---------------------------------------------------------------------------
module mfp_ahb_loader_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned FIFO_DEPTH   = 16,
   parameter int unsigned FLUSH_CYCLES = 8
) (
   input  logic                          HCLK,
   input  logic                          HRESET,
   input  logic                          big_endian,
   input  logic [ADDR_W-1:0]             ld_addr,
   input  logic [7:0]                    ld_byte,
   input  logic                          ld_valid,
   input  logic                          ld_active,
   mfp_ahb_loader_arbiter_if.master      bus,
   output logic                          grant_loader,
   output logic                          load_busy,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int unsigned LP_PW = $clog2(FIFO_DEPTH);
   localparam int unsigned LP_CW = LP_PW + 1;

   typedef enum logic [1:0] {L_IDLE, L_ADDR, L_DATA} l_state_t;

   l_state_t            r_state, w_state_nxt;
   logic [ADDR_W+7:0]   r_mem [FIFO_DEPTH];
   logic [LP_PW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [LP_CW-1:0]    r_count;
   logic                r_aowner, r_downer, r_overflow, r_ld_active_q;

   logic                w_empty, w_full, w_push, w_pop, w_drop, w_release;
   logic                w_xfer_done, w_x_ready, w_x_next, w_pending;
   logic [ADDR_W-1:0]   w_head_addr, w_x_addr;
   logic [7:0]          w_head_byte;
   logic [2:0]          w_x_size;
   logic [31:0]         w_x_data;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == LP_CW'(FIFO_DEPTH));
   // A pop in the same cycle frees the slot a full-queue push needs.
   assign w_push      = ld_valid && (!w_full || w_pop);
   assign w_drop      = ld_valid && w_full && !w_pop;
   assign w_head_addr = r_mem[r_rd_ptr][ADDR_W+7:8];
   assign w_head_byte = r_mem[r_rd_ptr][7:0];

   // Byte queue storage (contents need no reset; pointers define validity)
   always_ff @(posedge HCLK) begin
      if (w_push) r_mem[r_wr_ptr] <= {ld_addr, ld_byte};
   end

   // Queue pointers, level and sticky overflow
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_overflow    <= 1'b0;
         r_ld_active_q <= 1'b0;
      end else begin
         r_ld_active_q <= ld_active;
         if (w_push) r_wr_ptr <= r_wr_ptr + LP_PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + LP_PW'(1);
         if (w_push && !w_pop)      r_count <= r_count + LP_CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - LP_CW'(1);
         if (w_drop)                            r_overflow <= 1'b1;
         else if (ld_active && !r_ld_active_q)  r_overflow <= 1'b0;
      end
   end

`ifdef MFP_LOADER_COALESCE_EN
   localparam int unsigned LP_TW = $clog2(FLUSH_CYCLES + 1);

   // Assembly holds r_asm_cnt bytes starting at r_asm_addr, lowest address in [7:0].
   logic [ADDR_W-1:0] r_asm_addr;
   logic [31:0]       r_asm_data;
   logic [2:0]        r_asm_cnt;
   logic              r_flush;
   logic [LP_TW-1:0]  r_idle_cnt;
   logic              w_asm_word, w_can_take, w_contig, w_held_part, w_start_flush;

   assign w_asm_word    = (r_asm_cnt == 3'd4);
   assign w_can_take    = !r_flush && !w_asm_word && !w_empty;
   assign w_contig      = (r_asm_cnt == 3'd0) ||
                          (w_head_addr == r_asm_addr + ADDR_W'(r_asm_cnt));
   assign w_pop         = w_can_take && w_contig;
   assign w_held_part   = (r_asm_cnt != 3'd0) && !w_asm_word && !r_flush;
   // A breaking byte stays queued until the held bytes have been flushed.
   assign w_start_flush = w_held_part && !w_pop &&
                          ((w_can_take && !w_contig) ||
                           (r_idle_cnt == LP_TW'(FLUSH_CYCLES)) ||
                           (!ld_active && w_empty));

   assign w_x_ready = w_asm_word || (r_flush && (r_asm_cnt != 3'd0));
   assign w_x_next  = r_flush && (r_asm_cnt > 3'd1);
   assign w_x_addr  = r_asm_addr;
   assign w_x_size  = w_asm_word ? 3'd2 : 3'd0;
   assign w_x_data  = !w_asm_word ? {4{r_asm_data[7:0]}} :
                      big_endian  ? {r_asm_data[7:0], r_asm_data[15:8],
                                     r_asm_data[23:16], r_asm_data[31:24]} :
                                    r_asm_data;
   assign w_pending = (r_asm_cnt != 3'd0);

   // Word assembly; a flush drains the lowest held byte per completed transfer
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_asm_addr <= '0;
         r_asm_data <= '0;
         r_asm_cnt  <= '0;
         r_flush    <= 1'b0;
         r_idle_cnt <= '0;
      end else begin
         if (w_pop || !w_held_part)                    r_idle_cnt <= '0;
         else if (r_idle_cnt != LP_TW'(FLUSH_CYCLES))  r_idle_cnt <= r_idle_cnt + LP_TW'(1);

         if (w_pop) begin
            if (r_asm_cnt == 3'd0) begin
               r_asm_addr <= w_head_addr;
               r_asm_data <= {24'h0, w_head_byte};
               r_asm_cnt  <= 3'd1;
               r_flush    <= (w_head_addr[1:0] != 2'b00);
            end else begin
               r_asm_data[{r_asm_cnt[1:0], 3'b000} +: 8] <= w_head_byte;
               r_asm_cnt <= r_asm_cnt + 3'd1;
            end
         end else if (w_xfer_done) begin
            if (w_asm_word) begin
               r_asm_cnt <= 3'd0;
            end else begin
               r_asm_addr <= r_asm_addr + ADDR_W'(1);
               r_asm_data <= {8'h00, r_asm_data[31:8]};
               r_asm_cnt  <= r_asm_cnt - 3'd1;
               if (r_asm_cnt == 3'd1) r_flush <= 1'b0;
            end
         end else if (w_start_flush) begin
            r_flush <= 1'b1;
         end
      end
   end
`else
   logic w_unused_cfg;

   // Each queued byte is its own transfer; the head is popped when its data phase completes.
   assign w_pop        = (r_state == L_DATA) && bus.HREADY;
   assign w_x_ready    = !w_empty;
   assign w_x_next     = (r_count > LP_CW'(1));
   assign w_x_addr     = w_head_addr;
   assign w_x_size     = 3'd0;
   assign w_x_data     = {4{w_head_byte}};
   assign w_pending    = 1'b0;
   assign w_unused_cfg = big_endian ^ (FLUSH_CYCLES == 0);
`endif

   // Loader FSM state register
   always_ff @(posedge HCLK) begin
      if (HRESET) r_state <= L_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Loader FSM next state
   always_comb begin
      w_state_nxt = r_state;
      w_xfer_done = 1'b0;
      case (r_state)
         L_IDLE: if (r_aowner && w_x_ready) w_state_nxt = L_ADDR;
         L_ADDR: if (bus.HREADY) w_state_nxt = L_DATA;
         L_DATA: if (bus.HREADY) begin
            w_xfer_done = 1'b1;
            w_state_nxt = w_x_next ? L_ADDR : L_IDLE;
         end
         default: w_state_nxt = L_IDLE;
      endcase
   end

   // Ownership: CPU hands over only between its transfers, loader only when fully drained.
   assign w_release = !ld_active && w_empty && !w_pending && (r_state == L_IDLE);

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         r_aowner <= 1'b0;
         r_downer <= 1'b0;
      end else begin
         if (!r_aowner) begin
            if (ld_active && !bus.cpu_HTRANS[1] && bus.HREADY) r_aowner <= 1'b1;
         end else if (w_release) begin
            r_aowner <= 1'b0;
         end
         if (bus.HREADY) r_downer <= r_aowner;
      end
   end

   // Address/control follow the address-phase owner, write data the data-phase owner.
   assign bus.m_HADDR  = r_aowner ? w_x_addr : bus.cpu_HADDR;
   assign bus.m_HTRANS = r_aowner ? ((r_state == L_ADDR) ? 2'b10 : 2'b00) : bus.cpu_HTRANS;
   assign bus.m_HSIZE  = r_aowner ? w_x_size : bus.cpu_HSIZE;
   assign bus.m_HWRITE = r_aowner ? 1'b1 : bus.cpu_HWRITE;
   assign bus.m_HSIDE  = r_aowner ? 8'b0_0011_000 : bus.cpu_HSIDE;
   assign bus.m_HWDATA = r_downer ? w_x_data : bus.cpu_HWDATA;

   assign grant_loader = r_aowner;
   assign load_busy    = !w_empty || w_pending || (r_state != L_IDLE);
   assign overflow     = r_overflow;
   assign fifo_level   = r_count;
endmodule
